ex_mem: RTL and testbench
=========================

EX_MEM -- requirements
Module: ex_mem

Interface
- REQ-001 The block SHALL have no parameters; widths SHALL be fixed at 32-bit data, 5-bit register address, 64-bit HI/LO accumulator and 6-bit stall vector.
- REQ-002 Clk  input  1  pipeline clock; all state SHALL update on the rising edge only.
- REQ-003 Rst_n  input  1  reset, synchronous, active-low.
- REQ-004 stall  input  6  stall vector from the pipeline controller, bit0=PC, bit1=IF, bit2=ID, bit3=EX, bit4=MEM, bit5=WB.
- REQ-005 ex_wd  input  5  EX destination register address.
- REQ-006 ex_wreg  input  1  EX GPR write enable.
- REQ-007 ex_wdata  input  32  EX GPR write data.
- REQ-008 ex_hi, ex_lo  input  32 each  EX HI/LO write data.
- REQ-009 ex_whilo  input  1  EX HI/LO write enable.
- REQ-010 hilo_i  input  64  EX first-pass partial product for multiply-accumulate/subtract; already negated by EX for the subtract forms.
- REQ-011 cnt_i  input  2  EX multi-cycle step counter.
- REQ-012 mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo  output  5/1/32/32/32/1  registered copies of the EX result, driven to MEM; mem_whilo/mem_hi/mem_lo also drive the EX HI/LO forwarding path.
- REQ-013 hilo_o  output  64  partial product returned to EX as its hilo_temp input.
- REQ-014 cnt_o  output  2  step counter returned to EX as its cnt input.

Function
- REQ-015 Three stall cases SHALL be decoded every edge: ADVANCE when stall[3]=0; BUBBLE when stall[3]=1 and stall[4]=0; HOLD when stall[3]=1 and stall[4]=1.
- REQ-016 ADVANCE: each mem_* output SHALL load its ex_* input; hilo_o SHALL load 64'h0; cnt_o SHALL load 2'b00.
- REQ-017 BUBBLE: mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo and mem_whilo SHALL load zero; hilo_o SHALL load hilo_i; cnt_o SHALL load cnt_i.
- REQ-018 HOLD: all mem_* outputs SHALL retain their values; hilo_o SHALL load hilo_i; cnt_o SHALL load cnt_i.
- REQ-019 Latency SHALL be exactly one clock from ex_* to mem_* and from hilo_i/cnt_i to hilo_o/cnt_o; there SHALL be no combinational path from any input to any output.
- REQ-020 hilo_o and cnt_o SHALL be copied bit-exact, with no arithmetic, saturation or sign handling in this block.
- REQ-021 A BUBBLE SHALL never raise mem_wreg or mem_whilo, even while ex_wreg or ex_whilo is 1.
- REQ-022 The loopback SHALL survive any number of consecutive BUBBLE/HOLD cycles, re-capturing hilo_i/cnt_i each cycle.
- REQ-023 After a multi-cycle sequence ends (the next ADVANCE), cnt_o SHALL be 2'b00 so the next multiply-accumulate starts at step 0.
- REQ-024 stall[2:0] and stall[5] SHALL be ignored.
- REQ-025 Only stall[3] and stall[4] SHALL select the case; an upstream-only stall (stall[3]=0) SHALL be ADVANCE.

Reset
- REQ-026 When Rst_n=0 at a rising edge, every output SHALL load zero (mem_* all 0, hilo_o=64'h0, cnt_o=2'b00), regardless of stall.
- REQ-027 Reset SHALL take priority over every stall case.
- REQ-028 Reset asserted mid multi-cycle sequence SHALL abandon the sequence; after release the first ADVANCE SHALL behave as if no sequence had started.
- REQ-029 Outputs SHALL be unaffected by Rst_n between clock edges.

Verification
- REQ-030 Reset, then ADVANCE with ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h1234_5678 -> next edge mem_wd=3, mem_wreg=1, mem_wdata=32'h1234_5678, cnt_o=0.
- REQ-031 stall=6'b001111, hilo_i=64'h0000_0001_0000_0002, cnt_i=2'b01, ex_wreg=1, ex_whilo=1 -> mem_wreg=0, mem_whilo=0, hilo_o=64'h0000_0001_0000_0002, cnt_o=2'b01.
- REQ-032 Two-cycle multiply-accumulate: cycle1 BUBBLE with cnt_i=1; cycle2 ADVANCE with cnt_i=2, ex_whilo=1, ex_hi=32'h1, ex_lo=32'h5 -> mem_whilo=1, mem_hi=1, mem_lo=5, cnt_o=0, hilo_o=0.
- REQ-033 Capture mem_wdata=32'hAAAA_5555, then stall=6'b011111 for 3 cycles with ex_wdata changing -> mem_wdata stays 32'hAAAA_5555; cnt_o tracks cnt_i each cycle.
- REQ-034 Rst_n=0 for one edge while cnt_o=2'b01 and hilo_o nonzero -> all outputs 0 on that edge; following ADVANCE yields cnt_o=0.
- REQ-035 stall=6'b000111 with ex_* valid -> treated as ADVANCE; mem_* loads ex_*.

Source files
------------

// File: rtl/ex_mem.sv
// EX/MEM pipeline register.
// Carries the EX result (GPR write and HI/LO write) into MEM one clock later,
// and loops the multi-cycle multiply-accumulate state (partial product and
// step counter) back to EX while EX is stalled.
//
// Stall decoding, evaluated at every rising edge:
//   ADVANCE : stall[3]=0             -> MEM takes the EX result, loopback clears
//   BUBBLE  : stall[3]=1, stall[4]=0 -> MEM takes a nop, loopback re-captures
//   HOLD    : stall[3]=1, stall[4]=1 -> MEM keeps its value, loopback re-captures
// Synchronous active-low reset clears everything and wins over every stall case.
module ex_mem (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [5:0]  stall,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o
);

    typedef enum logic [1:0] {
        CASE_ADVANCE = 2'd0,
        CASE_BUBBLE  = 2'd1,
        CASE_HOLD    = 2'd2
    } stall_case_t;

    stall_case_t stall_case;

    // Only the EX and MEM stall bits matter here; the others belong to
    // other pipeline stages.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    // Decode which of the three stall cases applies this cycle.
    always_comb begin
        stall_case = CASE_ADVANCE;
        if (stall[3]) begin
            if (stall[4]) begin
                stall_case = CASE_HOLD;
            end else begin
                stall_case = CASE_BUBBLE;
            end
        end
    end

    // MEM-side result register: load on advance, nop on bubble, keep on hold.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            mem_wd    <= 5'd0;
            mem_wreg  <= 1'b0;
            mem_wdata <= 32'd0;
            mem_hi    <= 32'd0;
            mem_lo    <= 32'd0;
            mem_whilo <= 1'b0;
        end else begin
            case (stall_case)
                CASE_ADVANCE: begin
                    mem_wd    <= ex_wd;
                    mem_wreg  <= ex_wreg;
                    mem_wdata <= ex_wdata;
                    mem_hi    <= ex_hi;
                    mem_lo    <= ex_lo;
                    mem_whilo <= ex_whilo;
                end
                CASE_BUBBLE: begin
                    // A bubble must never produce a register-file write.
                    mem_wd    <= 5'd0;
                    mem_wreg  <= 1'b0;
                    mem_wdata <= 32'd0;
                    mem_hi    <= 32'd0;
                    mem_lo    <= 32'd0;
                    mem_whilo <= 1'b0;
                end
                default: begin
                    mem_wd    <= mem_wd;
                    mem_wreg  <= mem_wreg;
                    mem_wdata <= mem_wdata;
                    mem_hi    <= mem_hi;
                    mem_lo    <= mem_lo;
                    mem_whilo <= mem_whilo;
                end
            endcase
        end
    end

    // Multiply-accumulate loopback: cleared when EX advances so the next
    // sequence starts at step 0, otherwise copied bit-exact from EX.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            hilo_o <= 64'd0;
            cnt_o  <= 2'd0;
        end else if (stall_case == CASE_ADVANCE) begin
            hilo_o <= 64'd0;
            cnt_o  <= 2'd0;
        end else begin
            hilo_o <= hilo_i;
            cnt_o  <= cnt_i;
        end
    end

endmodule

// File: tb/tb_ex_mem.sv
// Bench for the EX/MEM pipeline register: directed scenarios with literal
// expectations, then randomized stall/reset/data traffic checked every cycle
// against a behavioural model.
module tb_ex_mem;

    logic        Clk;
    logic        Rst_n;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    ex_mem dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .stall    (stall),
        .ex_wd    (ex_wd),
        .ex_wreg  (ex_wreg),
        .ex_wdata (ex_wdata),
        .ex_hi    (ex_hi),
        .ex_lo    (ex_lo),
        .ex_whilo (ex_whilo),
        .hilo_i   (hilo_i),
        .cnt_i    (cnt_i),
        .mem_wd   (mem_wd),
        .mem_wreg (mem_wreg),
        .mem_wdata(mem_wdata),
        .mem_hi   (mem_hi),
        .mem_lo   (mem_lo),
        .mem_whilo(mem_whilo),
        .hilo_o   (hilo_o),
        .cnt_o    (cnt_o)
    );

    // Clock and reset block.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural model: what each output must hold after an edge.
    logic [4:0]  m_wd;
    logic        m_wreg;
    logic [31:0] m_wdata, m_hi, m_lo;
    logic        m_whilo;
    logic [63:0] m_hilo;
    logic [1:0]  m_cnt;

    always @(posedge Clk) begin
        if (Rst_n === 1'b0) begin
            {m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo} <= '0;
            m_hilo <= 64'd0;
            m_cnt  <= 2'd0;
        end else if (stall[3] == 1'b0) begin
            // EX moves on: MEM sees the EX result, loopback restarts.
            m_wd    <= ex_wd;
            m_wreg  <= ex_wreg;
            m_wdata <= ex_wdata;
            m_hi    <= ex_hi;
            m_lo    <= ex_lo;
            m_whilo <= ex_whilo;
            m_hilo  <= 64'd0;
            m_cnt   <= 2'd0;
        end else begin
            // EX stalled: MEM gets a nop if it can move, else keeps its value.
            if (stall[4] == 1'b0) begin
                {m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo} <= '0;
            end
            m_hilo <= hilo_i;
            m_cnt  <= cnt_i;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare on the falling edge, away from the active edge.
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("mem_wd",    64'(mem_wd),    64'(m_wd));
            chk("mem_wreg",  64'(mem_wreg),  64'(m_wreg));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            chk("mem_hi",    64'(mem_hi),    64'(m_hi));
            chk("mem_lo",    64'(mem_lo),    64'(m_lo));
            chk("mem_whilo", 64'(mem_whilo), 64'(m_whilo));
            chk("hilo_o",    hilo_o,         m_hilo);
            chk("cnt_o",     64'(cnt_o),     64'(m_cnt));
        end
    end

    // Driver helpers.
    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall    = 6'd0;
        ex_wd    = 5'd0;
        ex_wreg  = 1'b0;
        ex_wdata = 32'd0;
        ex_hi    = 32'd0;
        ex_lo    = 32'd0;
        ex_whilo = 1'b0;
        hilo_i   = 64'd0;
        cnt_i    = 2'd0;
    endtask

    task automatic randomize_inputs();
        int sel;
        sel = $urandom_range(0, 3);
        stall    = 6'($urandom);
        // Bias toward long stall runs so loopback re-capture is exercised.
        if (sel == 0) stall[4:3] = 2'b01;
        if (sel == 1) stall[4:3] = 2'b11;
        ex_wd    = 5'($urandom);
        ex_wreg  = 1'($urandom);
        ex_wdata = $urandom;
        ex_hi    = $urandom;
        ex_lo    = $urandom;
        ex_whilo = 1'($urandom);
        hilo_i   = {$urandom, $urandom};
        cnt_i    = 2'($urandom);
    endtask

    initial begin
        logic [31:0] held;
        clear_inputs();
        Rst_n = 1'b0;
        cycle();
        chk_en = 1;
        // Reset state.
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_cnt_o", 64'(cnt_o), 64'd0);

        // Plain advance after reset.
        Rst_n    = 1'b1;
        ex_wd    = 5'd3;
        ex_wreg  = 1'b1;
        ex_wdata = 32'h1234_5678;
        cycle();
        chk("adv_wd", 64'(mem_wd), 64'd3);
        chk("adv_wreg", 64'(mem_wreg), 64'd1);
        chk("adv_wdata", 64'(mem_wdata), 64'h1234_5678);
        chk("adv_cnt", 64'(cnt_o), 64'd0);

        // Bubble suppresses writes and captures the loopback.
        stall    = 6'b001111;
        hilo_i   = 64'h0000_0001_0000_0002;
        cnt_i    = 2'b01;
        ex_whilo = 1'b1;
        cycle();
        chk("bub_wreg", 64'(mem_wreg), 64'd0);
        chk("bub_whilo", 64'(mem_whilo), 64'd0);
        chk("bub_hilo", hilo_o, 64'h0000_0001_0000_0002);
        chk("bub_cnt", 64'(cnt_o), 64'd1);

        // Two-cycle multiply-accumulate.
        clear_inputs();
        stall = 6'b001000;
        cnt_i = 2'd1;
        hilo_i = 64'h0000_0000_dead_beef;
        cycle();
        chk("mac1_cnt", 64'(cnt_o), 64'd1);
        stall    = 6'b000000;
        cnt_i    = 2'd2;
        ex_whilo = 1'b1;
        ex_hi    = 32'h1;
        ex_lo    = 32'h5;
        cycle();
        chk("mac2_whilo", 64'(mem_whilo), 64'd1);
        chk("mac2_hi", 64'(mem_hi), 64'd1);
        chk("mac2_lo", 64'(mem_lo), 64'd5);
        chk("mac2_cnt", 64'(cnt_o), 64'd0);
        chk("mac2_hilo", hilo_o, 64'd0);

        // Hold keeps MEM while the loopback tracks EX.
        clear_inputs();
        ex_wdata = 32'hAAAA_5555;
        cycle();
        held = mem_wdata;
        for (int i = 1; i <= 3; i++) begin
            stall    = 6'b011111;
            ex_wdata = $urandom;
            cnt_i    = 2'(i);
            cycle();
            chk("hold_wdata", 64'(mem_wdata), 64'hAAAA_5555);
            chk("hold_cnt", 64'(cnt_o), 64'(i));
        end
        chk("hold_first", 64'(held), 64'hAAAA_5555);

        // Reset in the middle of a sequence abandons it.
        clear_inputs();
        stall  = 6'b001000;
        cnt_i  = 2'b01;
        hilo_i = 64'h0123_4567_89ab_cdef;
        cycle();
        chk("pre_rst_cnt", 64'(cnt_o), 64'd1);
        Rst_n = 1'b0;
        stall = 6'b011000;
        cycle();
        chk("rst_hilo", hilo_o, 64'd0);
        chk("rst_cnt", 64'(cnt_o), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        Rst_n = 1'b1;
        stall = 6'b000000;
        cnt_i = 2'd3;
        cycle();
        chk("post_rst_cnt", 64'(cnt_o), 64'd0);

        // Upstream-only stall is an advance.
        clear_inputs();
        stall    = 6'b000111;
        ex_wd    = 5'd17;
        ex_wreg  = 1'b1;
        ex_wdata = 32'hCAFE_F00D;
        cycle();
        chk("up_wd", 64'(mem_wd), 64'd17);
        chk("up_wdata", 64'(mem_wdata), 64'hCAFE_F00D);

        // Reset pulse between edges must not disturb outputs.
        stall = 6'b011000;
        Rst_n = 1'b0;
        #2;
        Rst_n = 1'b1;
        #1;
        chk("glitch_wdata", 64'(mem_wdata), 64'hCAFE_F00D);

        // Randomized traffic checked by the scoreboard every cycle.
        for (int n = 0; n < 600; n++) begin
            randomize_inputs();
            Rst_n = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
            cycle();
        end

        @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
